// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg -- shared FSM state encoding and default parameter values
// for the RISC-V result trace monitor.
package riscv_trace_pkg;

   // Monitor phases: core held in reset, core running and traced, trace closed.
   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } trace_state_e;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_RESET_HOLD = 4;
   localparam int DEF_MAX_CYCLES = 1000;
   localparam int DEF_TS_W       = 16;

endpackage : riscv_trace_pkg

// File: rtl/trace_fifo.sv
// trace_fifo -- circular trace buffer with occupancy count and a sticky
// overflow flag. A write is dropped only when the buffer is full and no pop
// happens in the same cycle; a simultaneous write and pop always succeeds.
module trace_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   rd_ready_i,
   output logic                   rd_valid_o,
   output logic [WIDTH-1:0]       rd_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;

   logic empty;
   logic full;
   logic pop;
   logic push;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign pop   = rd_ready_i && !empty;
   // A full buffer can still accept a write when the oldest entry leaves.
   assign push  = wr_en_i && (!full || pop);

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
      // increment wraps modulo DEPTH on its own.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (wr_en_i && !push) overflow_d = 1'b1;
   end

   // Control registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of block order.
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage, written at the write pointer on an accepted capture.
   // NOTE: the storage array has no reset; stale contents are never visible
   // because the read port is masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule : trace_fifo

// File: rtl/riscv_trace_monitor.sv
// riscv_trace_monitor -- holds the observed core in reset for RESET_HOLD
// cycles, then traces every change of its ALU result for MAX_CYCLES cycles
// into a circular buffer that a consumer drains with a valid/ready handshake.
// Optional feature macro: TRACE_TS_EN adds a per-entry RUN-cycle timestamp
// and the rd_ts output port.
module riscv_trace_monitor
   import riscv_trace_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int RESET_HOLD = DEF_RESET_HOLD,
   parameter int MAX_CYCLES = DEF_MAX_CYCLES,
   parameter int TS_W       = DEF_TS_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      alu_result,
   output logic                   core_reset,
   output logic                   done,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [DATA_W-1:0]      rd_data,
`ifdef TRACE_TS_EN
   output logic [TS_W-1:0]        rd_ts,
`endif
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int CNT_W  = $clog2(MAX_CYCLES + 1);
   localparam int HOLD_W = $clog2(RESET_HOLD + 1);
`ifdef TRACE_TS_EN
   localparam bit TS_EN  = 1'b1;
`else
   localparam bit TS_EN  = 1'b0;
`endif
   // Each buffer entry is the captured value, with the timestamp on top.
   localparam int ENTRY_W = DATA_W + (TS_EN ? TS_W : 0);

   trace_state_e      state_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [CNT_W-1:0]  run_cnt_q;
   logic              core_reset_q;
   logic              done_q;
   logic [DATA_W-1:0] last_q;

   logic               capture;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;

   // Phase sequencer with registered core_reset/done; the RUN counter ends at
   // MAX_CYCLES on the way into DONE and stays there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HOLD;
         hold_cnt_q   <= '0;
         run_cnt_q    <= '0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         unique case (state_q)
            HOLD: begin
               if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) begin
                  state_q      <= RUN;
                  core_reset_q <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            RUN: begin
               run_cnt_q <= run_cnt_q + 1'b1;
               if (run_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q      <= HOLD;
               hold_cnt_q   <= '0;
               core_reset_q <= 1'b1;
               done_q       <= 1'b0;
            end
         endcase
      end
   end

   // A capture is requested on the first RUN cycle and whenever the result
   // differs from the last requested value; a request dropped on overflow
   // still becomes the reference for the next comparison.
   assign capture = (state_q == RUN) &&
                    ((run_cnt_q == '0) || (alu_result != last_q));

   // Reference value for change detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= '0;
      end else if (capture) begin
         last_q <= alu_result;
      end
   end

`ifdef TRACE_TS_EN
   assign wr_entry = {TS_W'(run_cnt_q), alu_result};
   assign rd_ts    = rd_entry[ENTRY_W-1:DATA_W];
`else
   assign wr_entry = alu_result;
`endif
   assign rd_data  = rd_entry[DATA_W-1:0];

   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (capture),
      .wr_data_i  (wr_entry),
      .rd_ready_i (rd_ready),
      .rd_valid_o (rd_valid),
      .rd_data_o  (rd_entry),
      .count_o    (count),
      .overflow_o (overflow)
   );

   assign core_reset = core_reset_q;
   assign done       = done_q;

endmodule : riscv_trace_monitor

// File: tb/tb_riscv_trace_monitor.sv
// tb_riscv_trace_monitor -- scoreboard bench. The main instance is driven
// cycle by cycle while a queue model of the trace buffer predicts its
// contents; a negedge monitor compares status and pops expected entries on
// each handshake. A second instance with MAX_CYCLES=10 covers the end of run.
module tb_riscv_trace_monitor;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int RH    = 4;
   localparam int MC    = 1000;
   localparam int TSW   = 16;
   localparam int MC_S  = 10;

   typedef struct {
      logic [DW-1:0]  d;
      logic [TSW-1:0] ts;
   } ent_t;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic          reset;
   logic [DW-1:0] alu_result;
   logic          rd_ready;
   logic          core_reset, done, rd_valid, overflow;
   logic [DW-1:0] rd_data;
   logic [4:0]    count;
`ifdef TRACE_TS_EN
   logic [TSW-1:0] rd_ts;
`endif

   // short-run instance
   logic          rst_s;
   logic [DW-1:0] alu_s;
   logic          rdy_s;
   logic          core_reset_s, done_s, rd_valid_s, overflow_s;
   logic [DW-1:0] rd_data_s;
   logic [4:0]    count_s;
`ifdef TRACE_TS_EN
   logic [TSW-1:0] rd_ts_s;
`endif

   riscv_trace_monitor #(
      .DATA_W(DW), .DEPTH(DEPTH), .RESET_HOLD(RH), .MAX_CYCLES(MC), .TS_W(TSW)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .alu_result (alu_result),
      .core_reset (core_reset),
      .done       (done),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
`ifdef TRACE_TS_EN
      .rd_ts      (rd_ts),
`endif
      .count      (count),
      .overflow   (overflow)
   );

   riscv_trace_monitor #(
      .DATA_W(DW), .DEPTH(DEPTH), .RESET_HOLD(RH), .MAX_CYCLES(MC_S), .TS_W(TSW)
   ) u_short (
      .clk        (clk),
      .reset      (rst_s),
      .alu_result (alu_s),
      .core_reset (core_reset_s),
      .done       (done_s),
      .rd_valid   (rd_valid_s),
      .rd_ready   (rdy_s),
      .rd_data    (rd_data_s),
`ifdef TRACE_TS_EN
      .rd_ts      (rd_ts_s),
`endif
      .count      (count_s),
      .overflow   (overflow_s)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model of the main instance
   ent_t          exp_q[$];
   int            cyc;        // clock edges since reset release
   bit            model_ovf;
   logic [DW-1:0] last_val;
   bit            mon_on;
   ent_t          mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle on the main instance: drive inputs just after an edge,
   // predict what the next edge does, and fold it into the model after it.
   task automatic step(input logic [DW-1:0] val, input bit rdy);
      int   r;
      bit   pop;
      bit   pend_push;
      bit   pend_ovf;
      ent_t pend_ent;
      alu_result = val;
      rd_ready   = rdy;
      pend_push  = 1'b0;
      pend_ovf   = 1'b0;
      pend_ent.d  = '0;
      pend_ent.ts = '0;
      r = cyc - RH;
      if (cyc >= RH && cyc < RH + MC && (r == 0 || val != last_val)) begin
         last_val = val;
         pop = (exp_q.size() > 0) && rdy;
         if (exp_q.size() < DEPTH || pop) begin
            pend_push   = 1'b1;
            pend_ent.d  = val;
            pend_ent.ts = TSW'(r);
         end else begin
            pend_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #2;
      if (pend_push) exp_q.push_back(pend_ent);
      if (pend_ovf)  model_ovf = 1'b1;
      cyc++;
   endtask

   // Monitor: status against the model every cycle, data on each handshake.
   always @(negedge clk) begin
      if (mon_on && !reset) begin
         check("rd_valid", rd_valid, exp_q.size() != 0);
         check("count", count, exp_q.size());
         check("overflow", overflow, model_ovf);
         check("core_reset", core_reset, cyc < RH);
         check("done", done, cyc >= RH + MC);
         if (rd_valid && rd_ready && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("rd_data", rd_data, mon_e.d);
`ifdef TRACE_TS_EN
            check("rd_ts", rd_ts, mon_e.ts);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int caps, pops, s_idx;
      reset = 1'b1; rst_s = 1'b1;
      alu_result = '0; rd_ready = 1'b0; alu_s = '0; rdy_s = 1'b0;
      mon_on = 1'b0; cyc = 0; model_ovf = 1'b0; last_val = '0;
      #3;
      check("rst_core_reset", core_reset, 1);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_rd_data", rd_data, 0);

      // ---- short run: MAX_CYCLES=10, value changes every cycle ----
      @(posedge clk); #2;
      rst_s = 1'b0;
      s_idx = 0;
      for (int i = 0; i < 40; i++) begin
         alu_s = 100 + i;
         rdy_s = (i >= 24);
         @(negedge clk);
         caps = (i < RH) ? 0 : ((i - RH > MC_S) ? MC_S : i - RH);
         pops = (i < 24) ? 0 : ((i - 24 > MC_S) ? MC_S : i - 24);
         check("s_core_reset", core_reset_s, i < RH);
         check("s_done", done_s, i >= RH + MC_S);
         check("s_count", count_s, caps - pops);
         if (rdy_s && rd_valid_s) begin
            check("s_rd_data", rd_data_s, 104 + s_idx);
            s_idx++;
         end
         @(posedge clk); #2;
      end
      check("s_reads", s_idx, MC_S);
      check("s_overflow", overflow_s, 0);

      // ---- main instance: reset release and HOLD ----
      reset = 1'b0;
      cyc = 0; exp_q.delete(); model_ovf = 1'b0; mon_on = 1'b1;
      for (int i = 0; i < RH; i++) step($urandom, 1'($urandom_range(0, 1)));
      check("hold_released", core_reset, 0);
      check("hold_done", done, 0);

      // ---- 5,5,7,7,9 with no reads ----
      step(5, 0); step(5, 0); step(7, 0); step(7, 0); step(9, 0);
      step(9, 0);
      check("dedup_count", count, 3);
      for (int i = 0; i < 4; i++) step(9, 1);

      // ---- 20 distinct values into a 16-entry buffer ----
      for (int i = 0; i < 20; i++) step(1000 + i, 0);
      check("fill_count", count, DEPTH);
      check("fill_overflow", overflow, 1);
      for (int i = 0; i < 18; i++) step(1019, 1);

      // ---- asynchronous reset with five entries pending ----
      for (int i = 0; i < 5; i++) step(2000 + i, 0);
      check("pre_reset_count", count, 5);
      check("pre_reset_overflow", overflow, 1);
      #1;
      reset = 1'b1;
      #1;
      check("async_count", count, 0);
      check("async_rd_valid", rd_valid, 0);
      check("async_overflow", overflow, 0);
      check("async_core_reset", core_reset, 1);
      check("async_rd_data", rd_data, 0);
      exp_q.delete(); model_ovf = 1'b0; cyc = 0;
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b0;
      for (int i = 0; i < RH; i++) step($urandom, 1'($urandom_range(0, 1)));

      // ---- full buffer with reads every cycle ----
      step(3000, 0);
`ifdef TRACE_TS_EN
      check("first_ts", rd_ts, 0);
`endif
      for (int i = 1; i < DEPTH; i++) step(3000 + i, 0);
      for (int i = 0; i < 30; i++) step(4000 + i, 1);
      check("stream_count", count, DEPTH);
      check("stream_overflow", overflow, 0);
      for (int i = 0; i < 18; i++) step(4029, 1);

      // ---- random traffic: mostly stalled, then mostly draining ----
      for (int i = 0; i < 100; i++) step($urandom_range(0, 3), $urandom_range(0, 3) == 0);
      for (int i = 0; i < 100; i++) step($urandom_range(0, 3), $urandom_range(0, 3) != 0);
      for (int i = 0; i < 20; i++) step(last_val, 1);
      check("final_count", count, 0);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_riscv_trace_monitor
